// File: rtl/h14tx_pattern_gen.sv
// Test-pattern source for the DVI/HDMI output stage: bars, ramp, checker, box.
// Define H14TX_PATGEN_BOX_EN to build the bouncing box; otherwise mode 3 is flat mid-grey.
module h14tx_pattern_gen #(
  parameter int BitWidth     = 12,
  parameter int BitHeight    = 11,
  parameter int ActiveWidth  = 1280,
  parameter int ActiveHeight = 720,
  parameter int BoxSize      = 64,
  parameter int BoxStep      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic [1:0]           mode,
  output logic [2:0][7:0]      video,
  output logic                 frame_start,
  output logic [1:0]           active_mode
);

  localparam int BarW = ActiveWidth / 8;
  localparam int XW   = BitWidth + 1;
  localparam int YW   = BitHeight + 1;

  logic                act_q, act_d;
  logic                frame_q, frame_d;
  logic [2:0]          bar_idx_q, bar_idx_d;
  logic [BitWidth-1:0] bar_cnt_q, bar_cnt_d;
  logic [1:0]          mode_eff;
  logic [2:0]          bar_rgb;
  logic [2:0][7:0]     pix_d;
  logic [2:0][7:0]     video_q;
  logic                frame_start_q;
  logic [1:0]          active_mode_q;
  logic [7:0]          ramp_v;
  logic                chk_v;

`ifdef H14TX_PATGEN_BOX_EN
  logic [BitWidth-1:0]  x_q;
  logic [BitHeight-1:0] y_q;
  logic [BitWidth-1:0]  bx_q, bx_d;
  logic [BitHeight-1:0] by_q, by_d;
  logic                 dx_q, dx_d, dy_q, dy_d;
  logic                 in_box;
  assign ramp_v = x_q[7:0];
  assign chk_v  = x_q[5] ^ y_q[5];
`else
  logic [7:0] x_q;
  logic       y_q;
  assign ramp_v = x_q;
  assign chk_v  = x_q[5] ^ y_q;
`endif

  assign frame_d = (x == '0) && (y == '0);
  assign act_d   = ({1'b0, x} < XW'(ActiveWidth)) && ({1'b0, y} < YW'(ActiveHeight));

  // Bar index tracks the scan with a per-bar pixel counter instead of x / BarW.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_cnt_d = bar_cnt_q + 1'b1;
    if (x == '0) begin
      bar_idx_d = '0;
      bar_cnt_d = '0;
    end else if (bar_cnt_q == BitWidth'(BarW - 1)) begin
      bar_cnt_d = '0;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= 1'b0;
      frame_q   <= 1'b0;
      bar_idx_q <= '0;
      bar_cnt_q <= '0;
    end else begin
`ifdef H14TX_PATGEN_BOX_EN
      x_q <= x;
      y_q <= y;
`else
      x_q <= x[7:0];
      y_q <= y[5];
`endif
      act_q     <= act_d;
      frame_q   <= frame_d;
      bar_idx_q <= bar_idx_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  // The (0,0) pixel itself already belongs to the new frame's mode and box position.
  assign mode_eff = frame_q ? mode : active_mode_q;

`ifdef H14TX_PATGEN_BOX_EN
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (frame_q) begin
      if (dx_q) begin
        if ({1'b0, bx_q} + XW'(BoxSize + BoxStep) <= XW'(ActiveWidth)) begin
          bx_d = bx_q + BitWidth'(BoxStep);
        end else begin
          dx_d = 1'b0;
          bx_d = bx_q - BitWidth'(BoxStep);
        end
      end else if (bx_q >= BitWidth'(BoxStep)) begin
        bx_d = bx_q - BitWidth'(BoxStep);
      end else begin
        dx_d = 1'b1;
        bx_d = bx_q + BitWidth'(BoxStep);
      end
      if (dy_q) begin
        if ({1'b0, by_q} + YW'(BoxSize + BoxStep) <= YW'(ActiveHeight)) begin
          by_d = by_q + BitHeight'(BoxStep);
        end else begin
          dy_d = 1'b0;
          by_d = by_q - BitHeight'(BoxStep);
        end
      end else if (by_q >= BitHeight'(BoxStep)) begin
        by_d = by_q - BitHeight'(BoxStep);
      end else begin
        dy_d = 1'b1;
        by_d = by_q + BitHeight'(BoxStep);
      end
    end
  end

  assign in_box = ({1'b0, x_q} >= {1'b0, bx_d}) &&
                  ({1'b0, x_q} <  ({1'b0, bx_d} + XW'(BoxSize))) &&
                  ({1'b0, y_q} >= {1'b0, by_d}) &&
                  ({1'b0, y_q} <  ({1'b0, by_d} + YW'(BoxSize)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
`endif

  // {R,G,B} on/off per bar, white through black.
  always_comb begin
    case (bar_idx_q)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    pix_d = '0;
    if (act_q) begin
      case (mode_eff)
        2'd0:    pix_d = {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
        2'd1:    pix_d = {3{ramp_v}};
        2'd2:    pix_d = chk_v ? '1 : '0;
`ifdef H14TX_PATGEN_BOX_EN
        default: pix_d = in_box ? '1 : '0;
`else
        default: pix_d = {3{8'h80}};
`endif
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_q       <= '0;
      frame_start_q <= 1'b0;
      active_mode_q <= 2'd0;
    end else begin
      video_q       <= pix_d;
      frame_start_q <= frame_q;
      active_mode_q <= mode_eff;
    end
  end

  assign video       = video_q;
  assign frame_start = frame_start_q;
  assign active_mode = active_mode_q;

endmodule

// File: tb/tb_h14tx_pattern_gen.sv
// Directed bench for h14tx_pattern_gen; honours H14TX_PATGEN_BOX_EN when defined.
module tb_h14tx_pattern_gen;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] GREY    = 24'h808080;

  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     x;
  logic [10:0]     y;
  logic [1:0]      mode;
  logic [2:0][7:0] video;
  logic            frame_start;
  logic [1:0]      active_mode;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_cnt   = 0;
  int fs_exp   = 0;

  // Entry: {check, frame_start, active_mode[1:0], video[23:0]}
  logic [27:0] exp_q[$];
  string       tag_q[$];

  // Box position model, stepped on every (0,0) driven
  int bx_m = 0;
  int by_m = 0;
  bit dx_m = 1'b1;
  bit dy_m = 1'b1;

  int          bar_x [11] = '{0, 159, 160, 320, 480, 640, 800, 960, 1120, 1279, 1300};
  logic [23:0] bar_e [11] = '{WHITE, WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK, BLACK, BLACK};

  h14tx_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .mode        (mode),
    .video       (video),
    .frame_start (frame_start),
    .active_mode (active_mode)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_start) fs_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic upd_axis(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + 64 + 2 <= lim) p = p + 2;
      else begin d = 1'b0; p = p - 2; end
    end else begin
      if (p >= 2) p = p - 2;
      else begin d = 1'b1; p = p + 2; end
    end
  endtask

  // driver: one pixel per clock; the output for a pixel is checked two clocks later
  task automatic tick(input int px, input int py, input bit chk, input logic [23:0] ev,
                      input logic [1:0] eam, input string tag);
    logic [27:0] e;
    string       t;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[27]) begin
        check({t, "_vid"}, 32'(video), 32'(e[23:0]));
        check({t, "_fs"}, 32'(frame_start), 32'(e[26]));
        check({t, "_am"}, 32'(active_mode), 32'(e[25:24]));
      end
    end
    if (px == 0 && py == 0) begin
      fs_exp++;
      upd_axis(bx_m, dx_m, 1280);
      upd_axis(by_m, dy_m, 720);
    end
    x = px[11:0];
    y = py[10:0];
    exp_q.push_back({chk, (px == 0 && py == 0), eam, ev});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    repeat (2) tick(1400, 700, 1'b0, BLACK, 2'd0, "idle");
  endtask

  initial begin
    int          ax;
    int          ay;
    logic [23:0] ae;
    int          prev_bx;
    bit          hit;
    logic [23:0] e;

    rst  = 1'b1;
    x    = 12'd1400;
    y    = 11'd700;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vid", 32'(video), 32'h0);
    check("reset_fs", 32'(frame_start), 32'h0);
    check("reset_am", 32'(active_mode), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // bars over line 0 (frame start at (0,0)) and the last active line
    for (int i = 0; i < 1320; i++) begin
      hit = 1'b0;
      e   = BLACK;
      for (int j = 0; j < 11; j++) if (bar_x[j] == i) begin hit = 1'b1; e = bar_e[j]; end
      tick(i, 0, hit, e, 2'd0, $sformatf("bar_x%0d", i));
    end
    for (int i = 0; i < 1320; i++) begin
      if (i == 0)         tick(i, 719, 1'b1, WHITE, 2'd0, "l719_x0");
      else if (i == 800)  tick(i, 719, 1'b1, RED, 2'd0, "l719_x800");
      else if (i == 1279) tick(i, 719, 1'b1, BLACK, 2'd0, "l719_x1279");
      else if (i == 1280) tick(i, 719, 1'b1, BLACK, 2'd0, "l719_x1280");
      else                tick(i, 719, 1'b0, BLACK, 2'd0, "");
    end
    tick(5, 720, 1'b1, BLACK, 2'd0, "vblank");
    drain();
    check("fs_once", 32'(fs_cnt), 32'(fs_exp));

    // mode change mid-frame takes effect only at the next (0,0)
    tick(0, 0, 1'b1, WHITE, 2'd0, "f2_00");
    for (int i = 0; i < 1320; i++) begin
      if (i == 640) mode = 2'd2;
      if (i == 100)       tick(i, 360, 1'b1, WHITE, 2'd0, "mc_x100");
      else if (i == 700)  tick(i, 360, 1'b1, MAGENTA, 2'd0, "mc_x700");
      else if (i == 1000) tick(i, 360, 1'b1, BLUE, 2'd0, "mc_x1000");
      else                tick(i, 360, 1'b0, BLACK, 2'd0, "");
    end
    tick(0, 0, 1'b1, BLACK, 2'd2, "chk_00");
    tick(32, 0, 1'b1, WHITE, 2'd2, "chk_32_0");
    tick(32, 32, 1'b1, BLACK, 2'd2, "chk_32_32");
    tick(40, 70, 1'b1, WHITE, 2'd2, "chk_40_70");
    tick(1300, 0, 1'b1, BLACK, 2'd2, "chk_blank");

    // ramp
    mode = 2'd1;
    tick(0, 0, 1'b1, BLACK, 2'd1, "ramp_00");
    tick(0, 5, 1'b1, BLACK, 2'd1, "ramp_0");
    tick(255, 5, 1'b1, WHITE, 2'd1, "ramp_255");
    tick(256, 5, 1'b1, BLACK, 2'd1, "ramp_256");
    tick(100, 5, 1'b1, 24'h646464, 2'd1, "ramp_100");
    tick(1279, 5, 1'b1, WHITE, 2'd1, "ramp_1279");
    tick(1300, 5, 1'b1, BLACK, 2'd1, "ramp_blank");

    mode = 2'd3;
`ifdef H14TX_PATGEN_BOX_EN
    // bouncing box: probe edges each frame, and the two reversal points
    prev_bx = bx_m;
    for (int f = 0; f < 1230; f++) begin
      tick(0, 0, 1'b0, BLACK, 2'd3, "bf");
      tick(bx_m + 63, by_m, 1'b1, WHITE, 2'd3, "box_r_in");
      tick(bx_m + 64, by_m, 1'b1, BLACK, 2'd3, "box_r_out");
      tick(bx_m, by_m + 63, 1'b1, WHITE, 2'd3, "box_b_in");
      tick(bx_m, by_m + 64, 1'b1, BLACK, 2'd3, "box_b_out");
      if (bx_m > 0) tick(bx_m - 1, by_m, 1'b1, BLACK, 2'd3, "box_l_out");
      if (prev_bx == 1216 && bx_m == 1214) begin
        tick(1214, by_m, 1'b1, WHITE, 2'd3, "rev_1214");
        tick(1279, by_m, 1'b1, BLACK, 2'd3, "rev_1279");
      end
      if (prev_bx == 0 && bx_m == 2) begin
        tick(1, by_m, 1'b1, BLACK, 2'd3, "ret_1");
        tick(65, by_m, 1'b1, WHITE, 2'd3, "ret_65");
      end
      prev_bx = bx_m;
    end
`else
    tick(0, 0, 1'b1, GREY, 2'd3, "grey_00");
    tick(10, 10, 1'b1, GREY, 2'd3, "grey_in");
    tick(1279, 719, 1'b1, GREY, 2'd3, "grey_corner");
    tick(1280, 10, 1'b1, BLACK, 2'd3, "grey_hblank");
    tick(10, 720, 1'b1, BLACK, 2'd3, "grey_vblank");
`endif

    // asynchronous reset in the middle of a mode-3 line
    drain();
    tick(0, 0, 1'b0, BLACK, 2'd3, "rst_f");
`ifdef H14TX_PATGEN_BOX_EN
    ax = bx_m + 1;
    ay = by_m + 1;
    ae = WHITE;
`else
    ax = 10;
    ay = 10;
    ae = GREY;
`endif
    tick(ax, ay, 1'b0, BLACK, 2'd3, "pre_a");
    tick(ax + 1, ay, 1'b0, BLACK, 2'd3, "pre_b");
    @(posedge clk);
    #1;
    check("pre_rst_vid", 32'(video), 32'(ae));
    check("pre_rst_am", 32'(active_mode), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_vid", 32'(video), 32'h0);
    check("mid_rst_fs", 32'(frame_start), 32'h0);
    check("mid_rst_am", 32'(active_mode), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    bx_m = 0;
    by_m = 0;
    dx_m = 1'b1;
    dy_m = 1'b1;

    tick(0, 5, 1'b1, WHITE, 2'd0, "post_rst_x0");
    tick(1, 5, 1'b1, WHITE, 2'd0, "post_rst_x1");
`ifdef H14TX_PATGEN_BOX_EN
    tick(0, 0, 1'b1, BLACK, 2'd3, "post_rst_00");
    tick(2, 2, 1'b1, WHITE, 2'd3, "post_box_2_2");
    tick(65, 65, 1'b1, WHITE, 2'd3, "post_box_65_65");
    tick(66, 2, 1'b1, BLACK, 2'd3, "post_box_66_2");
    tick(1, 2, 1'b1, BLACK, 2'd3, "post_box_1_2");
    tick(2, 66, 1'b1, BLACK, 2'd3, "post_box_2_66");
`else
    tick(0, 0, 1'b1, GREY, 2'd3, "post_rst_00");
    tick(640, 360, 1'b1, GREY, 2'd3, "post_grey_in");
    tick(1300, 0, 1'b1, BLACK, 2'd3, "post_grey_blank");
`endif
    drain();
    check("fs_total", 32'(fs_cnt), 32'(fs_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
